// File: rtl/ahb_arb2.sv
// ahb_arb2: two-master AHB-Lite arbiter/multiplexer onto one slave port, with a
// one-entry address-phase hold per master. Define AHB_ARB2_RR_EN for round-robin.
module ahb_arb2 #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [AW-1:0] m0_addr,
  input  logic [1:0]    m0_trans,
  input  logic          m0_write,
  input  logic [1:0]    m0_size,
  input  logic [DW-1:0] m0_wdata,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_ready,
  input  logic [AW-1:0] m1_addr,
  input  logic [1:0]    m1_trans,
  input  logic          m1_write,
  input  logic [1:0]    m1_size,
  input  logic [DW-1:0] m1_wdata,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_ready,
  output logic [AW-1:0] s_addr,
  output logic [1:0]    s_trans,
  output logic          s_write,
  output logic [1:0]    s_size,
  output logic [DW-1:0] s_wdata,
  input  logic [DW-1:0] s_rdata,
  input  logic          s_ready
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_M0   = 2'b01,
    OWN_M1   = 2'b10
  } owner_t;

  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [1:0] HTRANS_NSEQ = 2'b10;
  localparam logic [1:0] HSIZE_WORD  = 2'b10;

  owner_t owner_q, owner_d;
  logic   dphase_write_q;

  logic          hold0_valid_q;
  logic [AW-1:0] hold0_addr_q;
  logic          hold0_write_q;
  logic [1:0]    hold0_size_q;
  logic          hold1_valid_q;
  logic [AW-1:0] hold1_addr_q;
  logic          hold1_write_q;
  logic [1:0]    hold1_size_q;

  logic live0, live1;
  logic req0, req1;
  logic grant0, grant1;
  logic fwd0, fwd1;
  logic capture0, capture1;

  // Only HTRANS[1] matters: SEQ/NSEQ are both forwarded, IDLE/BUSY never are.
  logic unused_trans_lsb;
  assign unused_trans_lsb = m0_trans[0] ^ m1_trans[0];

  // Ready depends only on registered state and s_ready, never on m_trans.
  assign m0_ready = ~hold0_valid_q & ((owner_q != OWN_M0) | s_ready);
  assign m1_ready = ~hold1_valid_q & ((owner_q != OWN_M1) | s_ready);

  assign live0 = m0_trans[1] & m0_ready;
  assign live1 = m1_trans[1] & m1_ready;
  assign req0  = hold0_valid_q | live0;
  assign req1  = hold1_valid_q | live1;

  assign m0_rdata = s_rdata;
  assign m1_rdata = s_rdata;

`ifdef AHB_ARB2_RR_EN
  logic last_q;

  // On contention the port that was not granted last wins; reset_n low
  // suppresses all grants so nothing partial reaches the slave.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (reset_n) begin
      if (req0 && req1) begin
        grant0 = last_q;
        grant1 = ~last_q;
      end else begin
        grant0 = req0;
        grant1 = req1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q <= 1'b0;
    end else if (s_ready && (grant0 || grant1)) begin
      last_q <= grant1;
    end
  end
`else
  // Fixed priority, port 0 first; reset_n low suppresses all grants.
  always_comb begin
    grant0 = reset_n & req0;
    grant1 = reset_n & req1 & ~req0;
  end
`endif

  assign fwd0     = grant0 & s_ready;
  assign fwd1     = grant1 & s_ready;
  assign capture0 = live0 & ~fwd0;
  assign capture1 = live1 & ~fwd1;

  // Address-phase mux: a held copy takes precedence over the live inputs.
  always_comb begin
    s_trans = HTRANS_IDLE;
    s_addr  = '0;
    s_write = 1'b0;
    s_size  = HSIZE_WORD;
    if (grant0) begin
      s_trans = HTRANS_NSEQ;
      if (hold0_valid_q) begin
        s_addr  = hold0_addr_q;
        s_write = hold0_write_q;
        s_size  = hold0_size_q;
      end else begin
        s_addr  = m0_addr;
        s_write = m0_write;
        s_size  = m0_size;
      end
    end else if (grant1) begin
      s_trans = HTRANS_NSEQ;
      if (hold1_valid_q) begin
        s_addr  = hold1_addr_q;
        s_write = hold1_write_q;
        s_size  = hold1_size_q;
      end else begin
        s_addr  = m1_addr;
        s_write = m1_write;
        s_size  = m1_size;
      end
    end
  end

  always_comb begin
    owner_d = owner_q;
    if (s_ready) begin
      if (grant0) begin
        owner_d = OWN_M0;
      end else if (grant1) begin
        owner_d = OWN_M1;
      end else begin
        owner_d = OWN_NONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner_q        <= OWN_NONE;
      dphase_write_q <= 1'b0;
    end else begin
      owner_q <= owner_d;
      if (s_ready) begin
        dphase_write_q <= s_write;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold0_valid_q <= 1'b0;
      hold0_addr_q  <= '0;
      hold0_write_q <= 1'b0;
      hold0_size_q  <= '0;
    end else if (capture0) begin
      hold0_valid_q <= 1'b1;
      hold0_addr_q  <= m0_addr;
      hold0_write_q <= m0_write;
      hold0_size_q  <= m0_size;
    end else if (fwd0) begin
      hold0_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold1_valid_q <= 1'b0;
      hold1_addr_q  <= '0;
      hold1_write_q <= 1'b0;
      hold1_size_q  <= '0;
    end else if (capture1) begin
      hold1_valid_q <= 1'b1;
      hold1_addr_q  <= m1_addr;
      hold1_write_q <= m1_write;
      hold1_size_q  <= m1_size;
    end else if (fwd1) begin
      hold1_valid_q <= 1'b0;
    end
  end

  // Write data follows the registered data-phase owner; zero otherwise.
  always_comb begin
    s_wdata = '0;
    if (dphase_write_q) begin
      case (owner_q)
        OWN_M0:  s_wdata = m0_wdata;
        OWN_M1:  s_wdata = m1_wdata;
        default: s_wdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_arb2.sv
// tb_ahb_arb2: directed + randomized bench for ahb_arb2 using a transfer-level
// arbitration model, a memory slave and a read-data scoreboard.
module tb_ahb_arb2;

`ifdef AHB_ARB2_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  typedef struct packed {
    logic [1:0]  trans;
    logic [31:0] addr;
    logic        write;
    logic [1:0]  size;
    logic [31:0] wdata;
  } xfer_t;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  xfer_t       cur [2];
  logic [31:0] m_wdata [2];
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_ready, m1_ready;
  logic [31:0] s_addr;
  logic [1:0]  s_trans;
  logic        s_write;
  logic [1:0]  s_size;
  logic [31:0] s_wdata;
  logic [31:0] s_rdata;
  logic        s_ready;

  ahb_arb2 #(.AW(32), .DW(32)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .m0_addr  (cur[0].addr),
    .m0_trans (cur[0].trans),
    .m0_write (cur[0].write),
    .m0_size  (cur[0].size),
    .m0_wdata (m_wdata[0]),
    .m0_rdata (m0_rdata),
    .m0_ready (m0_ready),
    .m1_addr  (cur[1].addr),
    .m1_trans (cur[1].trans),
    .m1_write (cur[1].write),
    .m1_size  (cur[1].size),
    .m1_wdata (m_wdata[1]),
    .m1_rdata (m1_rdata),
    .m1_ready (m1_ready),
    .s_addr   (s_addr),
    .s_trans  (s_trans),
    .s_write  (s_write),
    .s_size   (s_size),
    .s_wdata  (s_wdata),
    .s_rdata  (s_rdata),
    .s_ready  (s_ready)
  );

  // ---------------- memory slave ----------------
  logic [31:0] mem [256];
  bit          sl_v;
  bit          sl_write;
  logic [31:0] sl_addr;
  int          sl_waits;
  int          wait_max;
  int          force_wait;

  assign s_rdata = (sl_v && !sl_write) ? mem[sl_addr[9:2]] : 32'h0;

  // ---------------- reference model / scoreboard state ----------------
  logic [31:0] shadow [256];
  logic [31:0] exp_q [$];
  int          own;
  bit          last_g;
  bit          hold_mv [2];
  xfer_t       hold_m [2];
  xfer_t       dp_x;
  bit          mst_v [2];
  xfer_t       mst_x [2];
  bit          prev_rdy [2];
  xfer_t       dir_q0 [$];
  xfer_t       dir_q1 [$];
  int          p_req;
  logic [31:0] last_rd [2];
  int          n_checks;
  int          n_errors;
  int          win_all;
  int          win_m1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic xfer_t mk(input logic [1:0] trans, input logic [31:0] addr,
                               input logic write, input logic [31:0] wdata);
    xfer_t x;
    x.trans = trans;
    x.addr  = addr;
    x.write = write;
    x.size  = 2'b10;
    x.wdata = wdata;
    return x;
  endfunction

  task automatic pick(input int i, output xfer_t x);
    int r;
    if (i == 0 && dir_q0.size() != 0) begin
      x = dir_q0.pop_front();
    end else if (i == 1 && dir_q1.size() != 0) begin
      x = dir_q1.pop_front();
    end else begin
      r       = $urandom_range(0, 99);
      x.addr  = 32'h100 + 32'($urandom_range(0, 15)) * 4;
      x.write = 1'($urandom_range(0, 1));
      x.size  = 2'($urandom_range(0, 2));
      x.wdata = $urandom;
      if (r < p_req) x.trans = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b11;
      else           x.trans = ($urandom_range(0, 1) != 0) ? 2'b00 : 2'b01;
    end
  endtask

  task automatic model_reset();
    own      = -1;
    last_g   = 1'b0;
    exp_q.delete();
    sl_v     = 1'b0;
    sl_waits = 0;
    s_ready  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      hold_mv[i]  = 1'b0;
      mst_v[i]    = 1'b0;
      prev_rdy[i] = 1'b1;
      cur[i]      = mk(2'b00, 32'h0, 1'b0, 32'h0);
      m_wdata[i]  = 32'h0;
    end
  endtask

  // Evaluate the cycle before the coming edge, compare, then advance the model.
  task automatic model_cycle();
    bit    rdy [2];
    bit    live [2];
    bit    req [2];
    xfer_t src [2];
    int    win;
    logic  obs_rdy;
    logic [31:0] obs_rd;
    for (int i = 0; i < 2; i++) begin
      rdy[i]  = !hold_mv[i] && !(own == i && !s_ready);
      live[i] = cur[i].trans[1] && rdy[i];
      req[i]  = hold_mv[i] || live[i];
      src[i]  = hold_mv[i] ? hold_m[i] : cur[i];
    end
    win = -1;
    if (req[0] && req[1]) win = RR_EN ? (last_g ? 0 : 1) : 0;
    else if (req[0])      win = 0;
    else if (req[1])      win = 1;

    chk("m0_ready", m0_ready, rdy[0]);
    chk("m1_ready", m1_ready, rdy[1]);
    chk("s_trans", s_trans, (win >= 0) ? 2'b10 : 2'b00);
    chk("s_addr",  s_addr,  (win >= 0) ? src[win].addr  : 32'h0);
    chk("s_write", s_write, (win >= 0) ? src[win].write : 1'b0);
    chk("s_size",  s_size,  (win >= 0) ? src[win].size  : 2'b10);
    if (own < 0)           chk("s_wdata_idle", s_wdata, 32'h0);
    else if (dp_x.write)   chk("s_wdata", s_wdata, dp_x.wdata);

    // slave-side completion of the current data phase
    if (own >= 0 && s_ready) begin
      if (dp_x.write) shadow[dp_x.addr[9:2]] = dp_x.wdata;
      else            exp_q.push_back(shadow[dp_x.addr[9:2]]);
    end
    // master-side completion of read data phases
    for (int i = 0; i < 2; i++) begin
      if (rdy[i] && mst_v[i] && !mst_x[i].write) begin
        obs_rd = (i == 0) ? m0_rdata : m1_rdata;
        chk($sformatf("m%0d_rd_pending", i), exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) chk($sformatf("m%0d_rdata", i), obs_rd, exp_q.pop_front());
        last_rd[i] = obs_rd;
      end
    end

    if (s_ready) begin
      if (win >= 0) begin
        own        = win;
        dp_x       = src[win];
        hold_mv[win] = 1'b0;
        last_g     = (win == 1);
      end else begin
        own = -1;
      end
    end
    for (int i = 0; i < 2; i++) begin
      if (live[i] && !(s_ready && win == i)) begin
        hold_mv[i] = 1'b1;
        hold_m[i]  = cur[i];
      end
      if (rdy[i]) begin
        mst_v[i] = cur[i].trans[1];
        mst_x[i] = cur[i];
      end
      prev_rdy[i] = rdy[i];
    end
    obs_rdy = 1'b0;
    obs_rdy = obs_rdy;
  endtask

  task automatic slave_update();
    if (s_ready) begin
      if (sl_v && sl_write) mem[sl_addr[9:2]] = s_wdata;
      sl_v     = s_trans[1];
      sl_addr  = s_addr;
      sl_write = s_write;
      if (s_trans[1]) sl_waits = (force_wait >= 0) ? force_wait : int'($urandom_range(0, wait_max));
    end else if (sl_waits > 0) begin
      sl_waits--;
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive_inputs();
    xfer_t x;
    for (int i = 0; i < 2; i++) begin
      if (prev_rdy[i]) begin
        pick(i, x);
        cur[i] = x;
      end
      m_wdata[i] = mst_v[i] ? mst_x[i].wdata : $urandom;
    end
    s_ready = !sl_v || (sl_waits == 0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive_inputs();
    @(negedge clk);
    model_cycle();
    slave_update();
  endtask

  task automatic reset_mid();
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_mid_s_trans", s_trans, 2'b00);
    chk("rst_mid_s_addr", s_addr, 32'h0);
    chk("rst_mid_m0_ready", m0_ready, 1'b1);
    chk("rst_mid_m1_ready", m1_ready, 1'b1);
    dir_q0.delete();
    dir_q1.delete();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    n_checks   = 0;
    n_errors   = 0;
    p_req      = 0;
    wait_max   = 0;
    force_wait = -1;
    last_rd[0] = 32'h0;
    last_rd[1] = 32'h0;
    dp_x       = mk(2'b00, 32'h0, 1'b0, 32'h0);
    for (int k = 0; k < 256; k++) begin
      mem[k]    = $urandom;
      shadow[k] = mem[k];
    end
    reset_n = 1'b0;
    model_reset();
    #3;
    chk("rst_s_trans", s_trans, 2'b00);
    chk("rst_s_addr", s_addr, 32'h0);
    chk("rst_s_write", s_write, 1'b0);
    chk("rst_s_size", s_size, 2'b10);
    chk("rst_s_wdata", s_wdata, 32'h0);
    chk("rst_m0_ready", m0_ready, 1'b1);
    chk("rst_m1_ready", m1_ready, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // m0 alone: write then read back
    dir_q0.push_back(mk(2'b10, 32'h100, 1'b1, 32'h11223344));
    dir_q0.push_back(mk(2'b10, 32'h100, 1'b0, 32'h0));
    repeat (6) step();
    chk("t1_readback", last_rd[0], 32'h11223344);

    // simultaneous NSEQ from both masters
    dir_q0.push_back(mk(2'b10, 32'h200, 1'b1, 32'hA5A50202));
    dir_q1.push_back(mk(2'b10, 32'h300, 1'b0, 32'h0));
    repeat (6) step();

    // two slave wait states on m0 while m1 requests
    force_wait = 2;
    dir_q0.push_back(mk(2'b10, 32'h500, 1'b1, 32'h55550505));
    dir_q0.push_back(mk(2'b00, 32'h0, 1'b0, 32'h0));
    dir_q1.push_back(mk(2'b00, 32'h0, 1'b0, 32'h0));
    dir_q1.push_back(mk(2'b10, 32'h600, 1'b0, 32'h0));
    repeat (12) step();

    // both masters requesting continuously
    force_wait = 0;
    for (int k = 0; k < 10; k++) begin
      dir_q0.push_back(mk(2'b10, 32'h400 + 32'(k) * 4, 1'b1, $urandom));
      dir_q1.push_back(mk(2'b10, 32'h800 + 32'(k) * 4, 1'b0, 32'h0));
    end
    win_all = 0;
    win_m1  = 0;
    repeat (8) begin
      step();
      if (s_trans[1] && s_ready) begin
        win_all++;
        if (s_addr[11]) win_m1++;
      end
    end
    chk("t4_grants", win_all, 8);
    chk("t4_m1_grants", win_m1, RR_EN ? 4 : 0);

    // reset while a hold is pending, then confirm nothing is forwarded
    reset_mid();
    repeat (4) step();

    // BUSY then IDLE from m0
    dir_q0.push_back(mk(2'b01, 32'h700, 1'b1, 32'h0));
    dir_q0.push_back(mk(2'b00, 32'h700, 1'b0, 32'h0));
    repeat (4) step();

    // randomized traffic
    force_wait = -1;
    wait_max   = 3;
    p_req      = 60;
    repeat (300) step();
    wait_max   = 1;
    p_req      = 95;
    repeat (300) step();
    p_req      = 0;
    repeat (16) step();
    chk("sb_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ahb_arb2.md
Name: ahb_arb2

Overview:
Two-master AHB-Lite arbiter/multiplexer sharing a single AHB-Lite slave port, such as the testbench SRAM. It sits between two AHB-Lite masters (bus cycle generators or CPU models) and the slave. Each master has a one-entry address-phase hold register, so a losing master is accepted immediately and then stalled in its data phase. Each transfer is arbitrated individually; bursts are not locked.

Parameters:
AW, 32, address width for all ports
DW, 32, data width for all ports

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
m0_addr  in  AW  master 0 address
m0_trans  in  2  master 0 HTRANS
m0_write  in  1  master 0 HWRITE
m0_size  in  2  master 0 HSIZE
m0_wdata  in  DW  master 0 write data (data phase)
m0_rdata  out  DW  master 0 read data
m0_ready  out  1  master 0 HREADY
m1_addr, m1_trans, m1_write, m1_size, m1_wdata, m1_rdata, m1_ready  same as master 0, for master 1
s_addr  out  AW  slave address
s_trans  out  2  slave HTRANS
s_write  out  1  slave HWRITE
s_size  out  2  slave HSIZE
s_wdata  out  DW  slave write data
s_rdata  in  DW  slave read data
s_ready  in  1  slave HREADYOUT

Behaviour:
- Reset: reset_n is asynchronous and active-low; clock is clk.
  - Hold registers are cleared.
  - Data-phase owner = NONE.
  - RR pointer = 0.
  - Resulting outputs: s_trans=00, s_addr=0, s_write=0, s_size=2'b10, s_wdata=0, m0_ready=m1_ready=1.
- Live request: live_i = m_i_trans[1] & m_i_ready.
  - NSEQ and SEQ are both forwarded to the slave as NSEQ.
  - IDLE and BUSY are never forwarded.
- Request: req_i = hold_valid_i | live_i. The granted source is the held copy if hold_valid_i is set, else the live inputs.
- Ready: m_i_ready = ~hold_valid_i & (owner!=i | s_ready).
  - m_i_ready must not depend on m_i_trans (no combinational loop).
- Grant (combinational, fixed priority): port 0 beats port 1. No request -> s_trans=IDLE and s_addr=0.
- Address phase accepted when s_ready=1 and a grant exists. On that edge:
  - owner <= granted port;
  - hold_valid of the granted port is cleared;
  - the write flag is recorded for the data phase.
- Address accepted with no grant (s_ready=1, no request): owner <= NONE.
- Hold capture: a live request that is not forwarded on an edge (not granted, or s_ready=0) is captured into that port's hold register (addr/write/size).
  - The master sees m_i_ready=1, so its address phase is complete.
  - m_i_ready then stays low until the held transfer is forwarded and its slave data phase completes.
- Latency:
  - A live granted request adds 0 cycles.
  - A held request is forwarded at the earliest on the edge after capture.
  - Back-to-back pipelined transfers from one master run at full rate.
- Data phase:
  - s_wdata is muxed by the registered owner; 0 when owner=NONE.
  - s_rdata is broadcast to both m_i_rdata.
  - During slave wait states, m_owner_ready=0.
  - The non-owner's ready is governed by its hold state only.
- Simultaneous requests: both ports live on the same cycle -> port 0 is forwarded and port 1 is captured. Port 1 is forwarded on the next accepted edge, unless port 0 presents another live request and priority favours port 0.
- Hold limit: at most one held transfer per port. While hold_valid_i is set, m_i_ready=0, so the master cannot issue again.
- Reset mid-operation: pending holds are discarded, owner becomes NONE, and there is no partial transfer on the slave.

Optional Feature:
- Macro: AHB_ARB2_RR_EN.
- When defined: round-robin arbitration.
  - A 1-bit pointer records the last granted port and updates on each accepted address phase.
  - When both request, the port not granted last wins.
- When undefined: fixed priority, port 0 highest. The pointer logic is not compiled.

Test Plan:
1. m0 only: write 0x11223344 to 0x100, then read 0x100, s_ready always 1 -> s_addr=0x100 in the same cycle m0 presents it; m0_ready stays 1; read returns 0x11223344.
2. Both masters NSEQ in the same cycle (m0 write 0x200, m1 read 0x300):
   - s_addr=0x200 first, 0x300 on the next cycle;
   - m1_ready=0 for exactly the cycles until m1's data phase completes;
   - m1 data is correct.
3. Slave inserts 2 wait states on m0's transfer while m1 requests -> m1 is captured into hold; s_addr/s_trans stay stable during the wait; m1 is forwarded on the edge where s_ready=1.
4. Both masters request continuously for 8 cycles:
   - without AHB_ARB2_RR_EN, all 8 grants go to m0, and m1 waits with its hold valid;
   - with the macro, grants alternate m0, m1, m0, ...
5. reset_n pulsed low while m1 hold is valid -> immediately s_trans=00, m0_ready=m1_ready=1; no forwarding of the held transfer after release.
6. m0 issues BUSY then IDLE -> s_trans stays 00 and owner stays NONE.
